nnrv_mem_arb: RTL
=================

// Module: nnrv_mem_arb
// PURPOSE
//  Shares one single-port memory between the core's instruction fetch (IF) and load/store (LS) paths.
//  Accepts one transaction at a time and drives the memory port. Routes read data back to the owner
//  after a fixed memory latency. Arbitration is LS-priority with a starvation guard for IF.
//  Sits between nnrv_if / the LS unit and the memory inside nnrv_top.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width (byte enables are DW/8 bits)
//  MEM_LAT     1   cycles from o_mem_en to valid i_mem_rdata; legal range 1..7
//  STARVE_LIM  4   max consecutive LS grants while IF waits; legal range 1..15
// PORTS
//  i_clk        in   1     clock, all state on rising edge
//  i_rst        in   1     asynchronous reset, active-low
//  i_if_req     in   1     IF read request; held with addr until o_if_gnt
//  i_if_addr    in   AW    IF address
//  o_if_gnt     out  1     IF request accepted this cycle
//  o_if_rvalid  out  1     IF read data valid (1-cycle pulse)
//  o_if_rdata   out  DW    IF read data
//  i_ls_req     in   1     LS request; held with all fields until o_ls_gnt
//  i_ls_we      in   1     1 = write, 0 = read
//  i_ls_addr    in   AW    LS address
//  i_ls_wdata   in   DW    LS write data
//  i_ls_be      in   DW/8  LS byte enables (writes)
//  o_ls_gnt     out  1     LS request accepted this cycle
//  o_ls_rvalid  out  1     LS completion pulse (read data, or write ack)
//  o_ls_rdata   out  DW    LS read data; 0 on write ack
//  o_mem_en     out  1     memory access strobe (equals the grant cycle)
//  o_mem_we     out  1     memory write
//  o_mem_addr   out  AW    memory address
//  o_mem_wdata  out  DW    memory write data
//  o_mem_be     out  DW/8  memory byte enables; all-ones on IF reads
//  i_mem_rdata  in   DW    memory read data, valid MEM_LAT cycles after o_mem_en
//  o_busy       out  1     a transaction is outstanding
// BEHAVIOUR
//  - States: IDLE (no transaction outstanding), WAIT (transaction outstanding, lat_cnt counting).
//  - Grant is combinational. It is allowed in IDLE, or in WAIT on the cycle lat_cnt hits MEM_LAT (the response cycle).
//  - Grant cycle: o_mem_* driven from the winner, o_mem_en=1, owner/we latched, lat_cnt<=1, state->WAIT.
//  - Response cycle (lat_cnt==MEM_LAT): owner's rvalid=1 with rdata=i_mem_rdata (write: rdata=0).
//    Next state is WAIT if a new grant occurs that same cycle, else IDLE.
//  - Throughput: with MEM_LAT=1, back-to-back requests are accepted every cycle.
//    In general, one access per MEM_LAT cycles. No requests are accepted in the MEM_LAT-1 cycles between.
//  - Arbitration when both request: LS wins unless starve_cnt==STARVE_LIM, then IF wins.
//  - starve_cnt: +1 on each LS grant while i_if_req=1. Cleared on IF grant, or on any cycle with i_if_req=0.
//  - Saturates at STARVE_LIM.
//  - A requester that deasserts req before gnt is simply not served; gnt never asserts without req.
//  - When o_mem_en=0, the other o_mem_* outputs are 0.
//  - Reset (i_rst=0, async): state IDLE, lat_cnt/starve_cnt/owner=0.
//    All gnt, rvalid, rdata, o_mem_* and o_busy are 0 while reset is held.
//  - Reset mid-transaction discards it: no rvalid is produced after release.
//  - o_busy = (state==WAIT).
// TESTING
//  1. MEM_LAT=1, IF req addr 0x10, mem returns 0x00000013
//     -> gnt and mem_en (addr 0x10, we=0, be=F) in cycle 0; o_if_rvalid, rdata 0x13 in cycle 1.
//     IF req held continuously -> gnt every cycle.
//  2. IF and LS read asserted in the same cycle -> o_ls_gnt first; o_if_gnt at the next grant slot.
//     Each rvalid appears only on its own port.
//  3. STARVE_LIM=4, both requests held for 12 grants -> grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF,LS,LS.
//  4. LS write addr 0x100, wdata 0xDEADBEEF, be 0011
//     -> mem_we=1, be=0011 in the grant cycle; o_ls_rvalid with rdata 0 next cycle; o_if_rvalid stays 0.
//  5. MEM_LAT=3, IF req held -> grants at cycles 0,3,6 only; rvalid at cycles 3,6; o_busy=1 from cycle 1 on.
//  6. MEM_LAT=3, i_rst low at cycle 1 after an LS grant -> all outputs 0 immediately.
//     No o_ls_rvalid after release; first grant occurs in the first cycle after release with req=1.

Source files
------------

// File: rtl/nnrv_mem_arb.sv
// nnrv_mem_arb: shares one single-port memory between IF reads and LS accesses,
// with LS priority, an IF starvation guard and fixed-latency response routing.
module nnrv_mem_arb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_if_req,
    input  logic [AW-1:0]   i_if_addr,
    output logic            o_if_gnt,
    output logic            o_if_rvalid,
    output logic [DW-1:0]   o_if_rdata,
    input  logic            i_ls_req,
    input  logic            i_ls_we,
    input  logic [AW-1:0]   i_ls_addr,
    input  logic [DW-1:0]   i_ls_wdata,
    input  logic [DW/8-1:0] i_ls_be,
    output logic            o_ls_gnt,
    output logic            o_ls_rvalid,
    output logic [DW-1:0]   o_ls_rdata,
    output logic            o_mem_en,
    output logic            o_mem_we,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW-1:0]   o_mem_wdata,
    output logic [DW/8-1:0] o_mem_be,
    input  logic [DW-1:0]   i_mem_rdata,
    output logic            o_busy
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    localparam logic [2:0] LAT = 3'(MEM_LAT);
    localparam logic [3:0] LIM = 4'(STARVE_LIM);
    state_t     r_state;
    logic [2:0] r_lat_cnt;
    logic [3:0] r_starve_cnt;
    logic       r_owner_ls;
    logic       r_we;
    logic       w_resp, w_slot, w_if_win, w_gnt;
    always_comb begin
        w_resp   = r_state == S_WAIT && r_lat_cnt == LAT;
        // gating with i_rst keeps every combinational output low while reset is held
        w_slot   = i_rst && (r_state == S_IDLE || w_resp);
        w_if_win = i_if_req && (!i_ls_req || r_starve_cnt == LIM);
        o_if_gnt = w_slot && w_if_win;
        o_ls_gnt = w_slot && i_ls_req && !w_if_win;
        w_gnt    = o_if_gnt || o_ls_gnt;
    end
    assign o_mem_en    = w_gnt;
    assign o_mem_we    = o_ls_gnt && i_ls_we;
    assign o_mem_addr  = o_ls_gnt ? i_ls_addr : o_if_gnt ? i_if_addr : '0;
    assign o_mem_wdata = o_ls_gnt ? i_ls_wdata : '0;
    assign o_mem_be    = o_ls_gnt ? i_ls_be : o_if_gnt ? '1 : '0;
    assign o_if_rvalid = w_resp && !r_owner_ls;
    assign o_ls_rvalid = w_resp && r_owner_ls;
    assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
    assign o_ls_rdata  = (o_ls_rvalid && !r_we) ? i_mem_rdata : '0;
    assign o_busy      = r_state == S_WAIT;
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
            r_owner_ls   <= 1'b0;
            r_we         <= 1'b0;
        end else begin
            if (w_gnt) begin
                r_state    <= S_WAIT;
                r_lat_cnt  <= 3'd1;
                r_owner_ls <= o_ls_gnt;
                r_we       <= o_mem_we;
            end else if (w_resp) begin
                r_state <= S_IDLE;
            end else if (r_state == S_WAIT) begin
                r_lat_cnt <= r_lat_cnt + 3'd1;
            end
            r_starve_cnt <= (!i_if_req || o_if_gnt) ? 4'd0 :
                            (o_ls_gnt && r_starve_cnt != LIM) ? r_starve_cnt + 4'd1 : r_starve_cnt;
        end
    end
endmodule
